// File: rtl/link_framer.sv
`default_nettype none
// ============================================================================
//  Module   : link_framer
//  Function : Buffers the gapped merged readout stream in a small FIFO and
//             emits framed 64-bit link words (header, data, trailer) over a
//             valid/ready interface towards the inter-board link serializer.
//  Revision : 1.0  initial release
// ============================================================================
module link_framer #(
    parameter int FIFO_DEPTH = 16,   // entries of 54 bits, power of two 4..64
    parameter int HOLDOFF    = 3     // cycles after new_event that ignore inputs
) (
    input  logic        clk,
    input  logic        reset,       // asynchronous, active-low
    input  logic        new_event,
    input  logic [2:0]  BX,
    input  logic [53:0] in_dat,
    input  logic        in_valid,
    input  logic        in_done,
    output logic [63:0] out_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    output logic        busy
);

    localparam int c_AW   = $clog2(FIFO_DEPTH);
    localparam int c_HO_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

    localparam logic [c_AW:0]     c_FIFO_FULL = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_HO_W-1:0] c_HOLD_LOAD = c_HO_W'(HOLDOFF);
    localparam logic [6:0]        c_CNT_MAX   = 7'd127;

    localparam logic [7:0] c_K_HDR = 8'hBC;
    localparam logic [7:0] c_K_DAT = 8'hDA;
    localparam logic [7:0] c_K_TRL = 8'hEF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_DATA    = 2'd2,
        S_TRAILER = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Input FIFO
    logic [53:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_fcnt;

    // Frame context
    logic [c_HO_W-1:0] r_holdoff;
    logic [2:0]        r_bx;
    logic [2:0]        r_bx_pend;
    logic              r_pending;
    logic [6:0]        r_count;
    logic              r_trunc;
    logic              r_ovf;
    logic              r_done_seen;
    logic              r_loaded;     // header/trailer of the current state is in the output register

    // Output register
    logic [63:0] r_out_word;
    logic        r_out_valid;
    logic        r_overflow;

    // Combinational controls
    logic w_hold;
    logic w_xfer;
    logic w_out_free;
    logic w_empty;
    logic w_full;
    logic w_push_req;
    logic w_push;
    logic w_drop;
    logic w_pop;
    logic w_load_hdr;
    logic w_load_trl;
    logic w_start;       // new_event from IDLE
    logic w_abort;       // new_event while HEADER/DATA: truncate current frame
    logic w_trl_event;   // new_event while the trailer is still pending
    logic w_restart;     // trailer done, a new event is waiting: straight to HEADER

    assign w_hold     = (r_holdoff != '0);
    assign w_xfer     = r_out_valid & out_ready;
    assign w_out_free = ~r_out_valid | out_ready;
    assign w_empty    = (r_fcnt == '0);
    assign w_full     = (r_fcnt == c_FIFO_FULL);

    // A new_event flushes the FIFO on its edge, so a word arriving with it is discarded.
    assign w_push_req = in_valid & ~w_hold & ~new_event;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic and per-cycle datapath controls
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load_hdr  = 1'b0;
        w_load_trl  = 1'b0;
        w_start     = 1'b0;
        w_abort     = 1'b0;
        w_trl_event = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (new_event) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_HEADER;
                end
            end
            S_HEADER: begin
                if (new_event) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_TRAILER;
                end else if (!r_loaded) begin
                    w_load_hdr = w_out_free;
                end else if (w_xfer) begin
                    // Output register frees up as the header leaves: start data now.
                    w_pop       = ~w_empty;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (new_event) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_TRAILER;
                end else if (w_out_free && !w_empty) begin
                    w_pop = 1'b1;
                end else if (r_done_seen && w_empty && w_out_free && !w_push_req) begin
                    // A word arriving this cycle must still precede the trailer.
                    w_state_nxt = S_TRAILER;
                end
            end
            S_TRAILER: begin
                if (r_loaded && w_xfer) begin
                    if (r_pending || new_event) begin
                        w_restart   = 1'b1;
                        w_state_nxt = S_HEADER;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_trl_event = new_event;
                    w_load_trl  = ~r_loaded & w_out_free;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Holdoff counter: masks in_valid/in_done while the upstream sets up
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          r_holdoff <= '0;
        else if (new_event)  r_holdoff <= c_HOLD_LOAD;
        else if (w_hold)     r_holdoff <= r_holdoff - 1'b1;
    end

    // FIFO pointers and occupancy; any new_event flushes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fcnt   <= '0;
        end else if (new_event) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fcnt   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + 1'b1;
                2'b01:   r_fcnt <= r_fcnt - 1'b1;
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    // FIFO storage (contents are don't-care until written)
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_dat;
    end

    // Frame context: BX, pending event, count and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bx        <= '0;
            r_bx_pend   <= '0;
            r_pending   <= 1'b0;
            r_count     <= '0;
            r_trunc     <= 1'b0;
            r_ovf       <= 1'b0;
            r_done_seen <= 1'b0;
            r_loaded    <= 1'b0;
        end else begin
            if (w_start)        r_bx <= BX;
            else if (w_restart) r_bx <= new_event ? BX : r_bx_pend;

            if (w_restart) begin
                r_pending <= 1'b0;
            end else if (w_abort || w_trl_event) begin
                r_pending <= 1'b1;
                r_bx_pend <= BX;
            end

            if (w_start || w_restart)              r_count <= '0;
            else if (w_pop && r_count != c_CNT_MAX) r_count <= r_count + 1'b1;

            if (w_start || w_restart) r_trunc <= 1'b0;
            else if (w_abort)         r_trunc <= 1'b1;

            // A drop coinciding with a restart belongs to the new frame.
            if (w_drop)                      r_ovf <= 1'b1;
            else if (w_start || w_restart)   r_ovf <= 1'b0;

            if (new_event)                r_done_seen <= 1'b0;
            else if (in_done && !w_hold)  r_done_seen <= 1'b1;

            if (w_state_nxt != r_state)      r_loaded <= 1'b0;
            else if (w_load_hdr || w_load_trl) r_loaded <= 1'b1;
        end
    end

    // Output register: loads when free or transferring, otherwise holds
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_word  <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_overflow <= w_drop;
            if (w_load_hdr) begin
                r_out_word  <= {c_K_HDR, r_bx, 53'd0};
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_word  <= {c_K_DAT, 2'b00, r_mem[r_rd_ptr]};
                r_out_valid <= 1'b1;
            end else if (w_load_trl) begin
                r_out_word  <= {c_K_TRL, r_bx, r_count, r_trunc, r_ovf, 44'd0};
                r_out_valid <= 1'b1;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_word  = r_out_word;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_link_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_link_framer
//  Function : Self-checking bench for link_framer. Stimulus pushes expected
//             link words into a scoreboard queue; a monitor pops and compares
//             on every accepted output word.
//  Revision : 1.0  initial release
// ============================================================================
module tb_link_framer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        new_event = 1'b0;
    logic [2:0]  BX = '0;
    logic [53:0] in_dat = '0;
    logic        in_valid = 1'b0;
    logic        in_done = 1'b0;
    logic [63:0] out_word;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        overflow;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    int          xfers = 0;
    int          ovf_pulses = 0;
    int          rdy_mode = 0;          // 0: ready high, 1: toggle, 2: ready low
    logic [63:0] q[$];
    logic        stall_v = 1'b0;
    logic [63:0] stall_w = '0;

    link_framer #(.FIFO_DEPTH(16), .HOLDOFF(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .new_event (new_event),
        .BX        (BX),
        .in_dat    (in_dat),
        .in_valid  (in_valid),
        .in_done   (in_done),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] hdr(input logic [2:0] bx);
        return {8'hBC, bx, 53'd0};
    endfunction

    function automatic logic [53:0] dv(input int k);
        return {22'h155555, 32'(k)};
    endfunction

    function automatic logic [63:0] dat(input logic [53:0] d);
        return {8'hDA, 2'b00, d};
    endfunction

    function automatic logic [63:0] trl(input logic [2:0] bx, input logic [6:0] cnt,
                                        input logic trunc, input logic ovf);
        return {8'hEF, bx, cnt, trunc, ovf, 44'd0};
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (!(q.size() == 0 && !busy && !out_valid) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: timeout, %0d words outstanding, busy=%0b", name, q.size(), busy);
        end
    endtask

    // Link-side ready pattern, applied well clear of the clock edge
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: stall stability, scoreboard compare on each transfer, overflow pulses
    always @(negedge clk) begin
        if (!reset) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v)
                check("stall_hold", {out_valid, out_word}, {1'b1, stall_w});
            if (out_valid && out_ready) begin
                xfers++;
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got %h, expected none", out_word);
                end else begin
                    check("link_word", {1'b0, out_word}, {1'b0, q.pop_front()});
                end
            end
            stall_v = out_valid && !out_ready;
            stall_w = out_word;
            if (overflow) ovf_pulses++;
        end
    end

    // Header, three gapped data words, done at cycle 10
    task automatic frame_basic(input logic [2:0] bx, input int base, input string name);
        new_event = 1'b1;
        BX        = bx;
        q.push_back(hdr(bx));
        tick();
        new_event = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            in_valid = (c == 4 || c == 6 || c == 8);
            if (in_valid) begin
                in_dat = dv(base + c);
                q.push_back(dat(dv(base + c)));
            end
            in_done = (c == 10);
            tick();
        end
        in_valid = 1'b0;
        q.push_back(trl(bx, 7'd3, 1'b0, 1'b0));
        wait_idle(300, name);
        in_done = 1'b0;
    endtask

    initial begin
        int x0;

        // Reset state
        rdy_mode = 0;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_word", out_word, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b1;
        tick();

        // Basic frame, link always ready
        ovf_pulses = 0;
        frame_basic(3'd5, 16, "basic");
        check("basic_busy_after", busy, 0);
        check("basic_no_ovf", ovf_pulses, 0);

        // Same traffic with back-pressure every other cycle
        rdy_mode = 1;
        frame_basic(3'd5, 32, "toggle");
        rdy_mode = 0;
        tick();

        // Overflow: 1 parked + 16 buffered, 3 dropped
        ovf_pulses = 0;
        new_event = 1'b1;
        BX        = 3'd2;
        q.push_back(hdr(3'd2));
        tick();
        new_event = 1'b0;
        tick();
        tick();
        rdy_mode = 2;
        tick();
        for (int k = 1; k <= 20; k++) begin
            in_valid = 1'b1;
            in_dat   = dv(200 + k);
            if (k <= 17) q.push_back(dat(dv(200 + k)));
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("ovf_pulses", ovf_pulses, 3);
        check("ovf_busy", busy, 1);
        in_done = 1'b1;
        q.push_back(trl(3'd2, 7'd17, 1'b0, 1'b1));
        rdy_mode = 0;
        wait_idle(300, "overflow");

        // in_done still high from the last frame: masked during holdoff
        new_event = 1'b1;
        BX        = 3'd3;
        q.push_back(hdr(3'd3));
        x0 = xfers;
        tick();
        new_event = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin
                check("holdoff_busy", busy, 1);
                check("holdoff_xfers", xfers - x0, 1);
            end
            tick();
        end
        q.push_back(trl(3'd3, 7'd0, 1'b0, 1'b0));
        wait_idle(300, "holdoff");
        in_done = 1'b0;

        // Mid-frame new_event: truncated trailer then immediate header
        new_event = 1'b1;
        BX        = 3'd1;
        q.push_back(hdr(3'd1));
        tick();
        new_event = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            in_valid = (c == 4 || c == 5);
            if (in_valid) begin
                in_dat = dv(300 + c);
                q.push_back(dat(dv(300 + c)));
            end
            tick();
        end
        in_valid  = 1'b0;
        new_event = 1'b1;
        BX        = 3'd6;
        q.push_back(trl(3'd1, 7'd2, 1'b1, 1'b0));
        q.push_back(hdr(3'd6));
        tick();
        new_event = 1'b0;
        tick();
        tick();
        tick();
        in_done = 1'b1;
        q.push_back(trl(3'd6, 7'd0, 1'b0, 1'b0));
        wait_idle(300, "truncate");
        in_done = 1'b0;

        // Asynchronous reset mid-DATA with a stalled word in the output register
        new_event = 1'b1;
        BX        = 3'd4;
        q.push_back(hdr(3'd4));
        tick();
        new_event = 1'b0;
        tick();
        tick();
        tick();
        in_valid = 1'b1;
        in_dat   = dv(400);
        rdy_mode = 2;
        tick();
        in_dat = dv(401);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_word", out_word, dat(dv(400)));
        #2;
        reset = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_word", out_word, 0);
        check("arst_busy", busy, 0);
        check("arst_overflow", overflow, 0);
        check("arst_queue", q.size(), 0);
        q.delete();
        rdy_mode = 0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/link_framer.md
Name: link_framer

Overview:
- Sits directly downstream of the memory readout merger. Consumes its gapped merged data stream plus the valid and done strobes.
- Buffers accepted words in a small FIFO and emits one framed 64-bit link word per handshake: a header (BX), then data words, then a trailer (word count, status).
- Feeds the inter-board link serializer through a valid/ready interface.

Parameters:
- FIFO_DEPTH, 16, number of 54-bit entries in the input FIFO (power of two, 4..64).
- HOLDOFF, 3, cycles after new_event during which in_done and in_valid are ignored (covers the upstream setup window).

Ports:
- clk  in  1  processing clock.
- reset  in  1  asynchronous, active-low reset.
- new_event  in  1  one-cycle pulse marking the start of the next event.
- BX  in  3  bunch-crossing number, sampled on new_event.
- in_dat  in  54  merged memory data stream.
- in_valid  in  1  in_dat holds a valid word this cycle.
- in_done  in  1  upstream has no more data (level).
- out_word  out  64  framed link word.
- out_valid  out  1  out_word is valid.
- out_ready  in  1  link accepts out_word this cycle.
- overflow  out  1  one-cycle pulse when an input word is dropped.
- busy  out  1  a frame is in progress (state not IDLE).

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; FIFO empty; out_valid=0; out_word=0; overflow=0; busy=0; all counters and flags 0.
- Word formats:
  - Header: [63:56]=8'hBC, [55:53]=BX latched, [52:0]=0.
  - Data: [63:56]=8'hDA, [55:54]=0, [53:0]=FIFO entry.
  - Trailer: [63:56]=8'hEF, [55:53]=BX latched, [52:46]=data word count (saturates at 127), [45]=trunc, [44]=ovf, [43:0]=0.
- Output handshake:
  - out_word is registered.
  - Transfer occurs when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_word and out_valid hold stable.
  - A new word may load on the same cycle as a transfer, so throughput is 1 word/cycle.
- FIFO:
  - Push when in_valid & !holdoff.
  - If the FIFO is full and no pop occurs that cycle, the word is dropped, overflow pulses for 1 cycle, and sticky ovf is set.
  - Push and pop in the same cycle on a full FIFO: push accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- Holdoff counter: loads HOLDOFF on new_event and decrements to 0. in_valid and in_done are ignored while it is nonzero.
- States:
  - IDLE: on new_event, latch BX, flush the FIFO, clear count, trunc and ovf, then go to HEADER.
  - HEADER: load the header word; once it transfers, go to DATA.
  - DATA:
    - Whenever the output register is free or transferring and the FIFO is non-empty, pop one entry into a data word and increment count.
    - done_seen is set when in_done=1 with holdoff at 0.
    - When done_seen=1, the FIFO is empty and the last data word has transferred, go to TRAILER.
  - TRAILER: load the trailer; once it transfers, go to IDLE.
- new_event mid-frame (HEADER or DATA):
  - Set trunc and set pending_new; the new BX goes into a holding register.
  - The FIFO is flushed at that edge; words still in the output register complete.
  - State goes to TRAILER; the trailer uses the old BX with trunc=1.
  - After the trailer transfers, go to HEADER with the pending BX (not IDLE); holdoff runs from the new_event edge.
- new_event while in TRAILER: the trailer completes unchanged (trunc not set); pending_new routes to HEADER afterwards.
- New word after done_seen but before TRAILER (holdoff expired): still pushed and emitted before the trailer.
- busy=1 in every state except IDLE.

Test Plan:
- Reset, then new_event with BX=5; 3 words pushed on non-consecutive cycles; in_done at cycle 10; out_ready=1 → outputs BC header with BX=5, then 3 DA words in order, then trailer EF with count=3, trunc=0, ovf=0; busy returns to 0.
- Same traffic with out_ready toggling 1/0 every cycle → identical word sequence; out_word stable during every stall; no loss.
- out_ready=0; push 20 words into the FIFO_DEPTH=16 buffer → 3 overflow pulses (16 words held, 1 word parked in the output register, 3 dropped); after release, trailer shows count=17, ovf=1.
- in_done held high from the previous event when new_event asserts → done ignored for 3 cycles; a header is emitted and the frame does not close before the holdoff expires.
- new_event with BX=6 after 2 data words of frame BX=1 → trailer with BX=1, count=2, trunc=1, then immediately a header with BX=6.
- Assert reset low mid-DATA with out_valid=1 → out_valid, out_word, busy and overflow all 0 immediately (asynchronous), state IDLE.
